// File: rtl/attn_pkg.sv
// Shared types and default geometry for the attention score/exp/softmax pipeline.
package attn_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIVIDE  = 2'd1,
        EMIT    = 2'd2
    } softmax_state_t;

    localparam int unsigned ATTN_N_SCORES = 4;
    localparam int unsigned ATTN_DATA_W   = 8;
    localparam int unsigned ATTN_OUT_W    = 8;
    localparam int unsigned Q0_8_ONE      = 256;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle; fixed Q_W-cycle latency after start.
module seq_divider #(
    parameter int unsigned NUM_W = 16,
    parameter int unsigned DEN_W = 10,
    parameter int unsigned Q_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quot
);

    localparam int unsigned DSH_W = DEN_W + Q_W - 1;
    localparam int unsigned CNT_W = $clog2(Q_W + 1);

    logic [NUM_W-1:0] r_rem;
    logic [DSH_W-1:0] r_dsh;
    logic [Q_W-2:0]   r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic             w_ge;
    logic [NUM_W-1:0] w_sub;
    logic [Q_W-1:0]   w_quot_nxt;

    // When the trial subtraction succeeds the shifted divisor fits in NUM_W bits.
    always_comb begin
        w_ge       = DSH_W'(r_rem) >= r_dsh;
        w_sub      = r_rem - r_dsh[NUM_W-1:0];
        w_quot_nxt = {r_quot, w_ge};
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == CNT_W'(1));
    assign quot = w_quot_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dsh  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= num;
            r_dsh  <= DSH_W'(den) << (Q_W - 1);
            r_quot <= '0;
            r_cnt  <= CNT_W'(Q_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_sub : r_rem;
            r_dsh  <= r_dsh >> 1;
            r_quot <= w_quot_nxt[Q_W-2:0];
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/softmax_norm.sv
// Buffers a row of exponentials, sums them, and streams e_i/sum as Q0.OUT_W weights.
module softmax_norm
    import attn_pkg::*;
#(
    parameter int unsigned N_SCORES = ATTN_N_SCORES,
    parameter int unsigned DATA_W   = ATTN_DATA_W,
    parameter int unsigned OUT_W    = ATTN_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ex_slv_in,
    input  logic              vld_slv_in,
    output logic              rdy_slv_out,
    output logic [OUT_W-1:0]  w_mst_out,
    output logic              vld_mst_out,
    output logic              last_mst_out,
    input  logic              rdy_mst_in
);

    localparam int unsigned SUM_W = DATA_W + $clog2(N_SCORES);
    localparam int unsigned IDX_W = $clog2(N_SCORES);
    localparam int unsigned NUM_W = DATA_W + OUT_W;
    localparam int unsigned Q_W   = OUT_W + 1;

    localparam logic [OUT_W:0]   W_ONE = (OUT_W + 1)'(1) << OUT_W;
    localparam logic [OUT_W-1:0] W_UNI = OUT_W'(W_ONE / N_SCORES);
    localparam logic [OUT_W-1:0] W_SAT = {OUT_W{1'b1}};

    softmax_state_t r_state, w_state_nxt;

    logic [IDX_W-1:0]  r_idx;
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_buf [N_SCORES];
    logic [OUT_W-1:0]  r_w;
    logic              r_vld;

    logic              w_last_idx;
    logic              w_xfer_in;
    logic              w_xfer_out;
    logic              w_start;
    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [Q_W-1:0]    w_div_quot;
    logic [IDX_W-1:0]  w_num_idx;
    logic [NUM_W-1:0]  w_num;
    logic [SUM_W-1:0]  w_den;
    logic [OUT_W-1:0]  w_weight;

    assign w_last_idx   = (r_idx == IDX_W'(N_SCORES - 1));
    assign w_xfer_in    = (r_state == COLLECT) && vld_slv_in;
    assign w_xfer_out   = (r_state == EMIT) && r_vld && rdy_mst_in;
    assign rdy_slv_out  = (r_state == COLLECT);
    assign w_mst_out    = r_w;
    assign vld_mst_out  = r_vld;
    assign last_mst_out = (r_state == EMIT) && w_last_idx;

    // The divider is loaded on the edge that enters DIVIDE, so the operands are
    // taken from next-state values: row restarts at index 0, sum includes the last input.
    always_comb begin
        w_num_idx = (r_state == COLLECT) ? '0 : r_idx + 1'b1;
        w_num     = {r_buf[w_num_idx], {OUT_W{1'b0}}};
        w_den     = (r_state == COLLECT) ? r_sum + SUM_W'(ex_slv_in) : r_sum;
    end

    always_comb begin
        if (r_sum == '0) begin
            w_weight = W_UNI;
        end else if (w_div_quot[OUT_W]) begin
            w_weight = W_SAT;
        end else begin
            w_weight = w_div_quot[OUT_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_xfer_in && w_last_idx) begin
                    w_state_nxt = DIVIDE;
                    w_start     = 1'b1;
                end
            end
            DIVIDE: begin
                if (w_div_done) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_xfer_out) begin
                    if (w_last_idx) begin
                        w_state_nxt = COLLECT;
                    end else begin
                        w_state_nxt = DIVIDE;
                        w_start     = 1'b1;
                    end
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    assign w_div_start = w_start && !w_div_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_sum <= '0;
            r_w   <= '0;
            r_vld <= 1'b0;
            for (int i = 0; i < N_SCORES; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_xfer_in) begin
                        r_buf[r_idx] <= ex_slv_in;
                        r_sum        <= r_sum + SUM_W'(ex_slv_in);
                        r_idx        <= w_last_idx ? '0 : r_idx + 1'b1;
                    end
                end
                DIVIDE: begin
                    if (w_div_done) begin
                        r_w   <= w_weight;
                        r_vld <= 1'b1;
                    end
                end
                EMIT: begin
                    if (w_xfer_out) begin
                        r_vld <= 1'b0;
                        if (w_last_idx) begin
                            r_sum <= '0;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W),
        .Q_W   (Q_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (w_div_start),
        .num   (w_num),
        .den   (w_den),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quot  (w_div_quot)
    );

endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm: expected weights queued at stimulus, checked at output.
module tb_softmax_norm;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W  = 8;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] ex_slv_in;
    logic              vld_slv_in;
    logic              rdy_slv_out;
    logic [OUT_W-1:0]  w_mst_out;
    logic              vld_mst_out;
    logic              last_mst_out;
    logic              rdy_mst_in;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [OUT_W:0] sb [$];
    bit          bp_mode;
    int unsigned bp_cnt;

    softmax_norm #(
        .N_SCORES (N),
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_slv_in    (ex_slv_in),
        .vld_slv_in   (vld_slv_in),
        .rdy_slv_out  (rdy_slv_out),
        .w_mst_out    (w_mst_out),
        .vld_mst_out  (vld_mst_out),
        .last_mst_out (last_mst_out),
        .rdy_mst_in   (rdy_mst_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: floor(e*2^OUT_W/sum), saturated; zero sum gives 2^OUT_W/N.
    function automatic logic [OUT_W-1:0] ref_weight(input int unsigned e, input int unsigned s);
        int unsigned q;
        if (s == 0) return OUT_W'(256 / N);
        q = (e * 256) / s;
        if (q > 255) q = 255;
        return OUT_W'(q);
    endfunction

    task automatic put_in(input int unsigned v);
        int n;
        n = 0;
        ex_slv_in  = DATA_W'(v);
        vld_slv_in = 1'b1;
        @(negedge clk);
        while (!rdy_slv_out && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq("in_timeout", rdy_slv_out, 1);
        @(posedge clk);
        #1;
        vld_slv_in = 1'b0;
    endtask

    task automatic send_row(input int unsigned e0, input int unsigned e1,
                            input int unsigned e2, input int unsigned e3);
        int unsigned row [4];
        int unsigned s;
        row = '{e0, e1, e2, e3};
        s = e0 + e1 + e2 + e3;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({(i == 3) ? 1'b1 : 1'b0, ref_weight(row[i], s)});
        end
        for (int i = 0; i < 4; i++) put_in(row[i]);
    endtask

    // Counts edges from the last-input accept edge through the edge raising vld.
    task automatic check_latency(input string tag);
        int n;
        n = 0;
        while (!vld_mst_out && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, n + 1, OUT_W + 2);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output-side backpressure generator: hold rdy low 5 cycles per weight in bp_mode.
    initial begin
        rdy_mst_in = 1'b1;
        bp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                rdy_mst_in = 1'b1;
            end else if (vld_mst_out) begin
                if (bp_cnt < 5) begin
                    rdy_mst_in = 1'b0;
                    bp_cnt++;
                end else begin
                    rdy_mst_in = 1'b1;
                end
            end else begin
                rdy_mst_in = 1'b0;
                bp_cnt = 0;
            end
        end
    end

    // Output monitor: scoreboard pops, hold-stability and row-turnaround checks.
    initial begin
        logic             prev_vld, prev_rdy, prev_last, pend_last;
        logic [OUT_W-1:0] prev_w;
        logic [OUT_W:0]   exp_e;
        prev_vld = 1'b0; prev_rdy = 1'b0; prev_last = 1'b0; pend_last = 1'b0; prev_w = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld  = 1'b0;
                pend_last = 1'b0;
            end else begin
                if (pend_last) begin
                    check_eq("rdy_after_last", rdy_slv_out, 1);
                    pend_last = 1'b0;
                end
                if (prev_vld && !prev_rdy) begin
                    check_eq("hold_vld", vld_mst_out, 1);
                    check_eq("hold_w", w_mst_out, prev_w);
                    check_eq("hold_last", last_mst_out, prev_last);
                end
                if (vld_mst_out && rdy_mst_in) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_w", vld_mst_out, 0);
                    end else begin
                        exp_e = sb.pop_front();
                        check_eq("weight", w_mst_out, exp_e[OUT_W-1:0]);
                        check_eq("last", last_mst_out, exp_e[OUT_W]);
                        pend_last = exp_e[OUT_W];
                    end
                end
                prev_vld  = vld_mst_out;
                prev_rdy  = rdy_mst_in;
                prev_w    = w_mst_out;
                prev_last = last_mst_out;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        bp_mode = 1'b0;
        rst = 1'b1;
        ex_slv_in = '0;
        vld_slv_in = 1'b0;
        #2;
        check_eq("rst_vld", vld_mst_out, 0);
        check_eq("rst_w", w_mst_out, 0);
        check_eq("rst_last", last_mst_out, 0);
        check_eq("rst_rdy_slv", rdy_slv_out, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Uniform row with latency check
        send_row(64, 64, 64, 64);
        check_eq("divide_rdy_slv", rdy_slv_out, 0);
        check_latency("lat_uniform");
        wait_drain("drain_uniform");

        // Ramp row; stray input pulses while busy must be ignored
        send_row(10, 20, 30, 40);
        ex_slv_in = 8'd99;
        vld_slv_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("busy_rdy_slv", rdy_slv_out, 0);
        end
        @(posedge clk);
        #1;
        vld_slv_in = 1'b0;
        wait_drain("drain_ramp");

        // Saturation and zero inputs
        send_row(128, 0, 0, 0);
        wait_drain("drain_sat");

        // Zero sum: uniform weights with unchanged timing
        send_row(0, 0, 0, 0);
        check_latency("lat_zero");
        wait_drain("drain_zero");

        // Backpressure on the ramp row
        bp_mode = 1'b1;
        send_row(10, 20, 30, 40);
        wait_drain("drain_bp");
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back rows: sum must restart for the second row
        send_row(64, 64, 64, 64);
        send_row(10, 20, 30, 40);
        wait_drain("drain_b2b");

        // Asynchronous reset in the DIVIDE phase of weight 2
        send_row(64, 64, 64, 64);
        begin
            int n;
            n = 0;
            while (sb.size() > 2 && n < 500) begin
                @(posedge clk);
                n++;
            end
            check_eq("reach_w2", sb.size(), 2);
        end
        @(posedge clk);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_vld", vld_mst_out, 0);
        check_eq("async_rst_rdy_slv", rdy_slv_out, 1);
        check_eq("async_rst_last", last_mst_out, 0);
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_row(64, 64, 64, 64);
        wait_drain("drain_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
